// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for the wrap-bit synchronous FIFO; optional sticky overflow_flag under `FIFO_WR_OVERFLOW_FLAG_EN.
// Latency: wr_en/flags/occupancy are combinational; wr_ptr advances by WPW on the posedge after an accepted write.
// Backpressure: none beyond full_flag; a request while full is dropped (and recorded by overflow_flag when enabled).
module fifo_wr_ctrl #(
  parameter int W_DATA_WIDTH = 16,
  parameter int MEM_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_request,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  wr_en,
  output logic                  full_flag,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   occupancy
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  ,
  input  logic                  clr_overflow,
  output logic                  overflow_flag
`endif
);

  localparam int WPW      = W_DATA_WIDTH / MEM_WIDTH;
  localparam int AF_WORDS = AFULL_MARGIN * WPW;
  localparam int PW       = ADDR_WIDTH + 1;

  logic [31:0] free_words;

  // Modular subtraction makes the wrap bit distinguish full from empty at equal index.
  assign occupancy   = wr_ptr - rd_ptr;
  assign free_words  = 32'(FIFO_DEPTH) - 32'(occupancy);
  assign full_flag   = free_words < 32'(WPW);
  assign almost_full = full_flag | (free_words <= 32'(AF_WORDS));
  assign wr_en       = wr_request & ~full_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(WPW);
    end
  end

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  // A new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_flag <= 1'b0;
    end else if (wr_request & full_flag) begin
      overflow_flag <= 1'b1;
    end else if (clr_overflow) begin
      overflow_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: a WPW=1 and a WPW=2 instance, vector table, corner sequences, random vs word-count model.
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req;
  logic [4:0] a_rd, b_rd, a_ptr, b_ptr, a_occ, b_occ;
  logic       a_en, a_full, a_af, b_en, b_full, b_af;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  logic       a_clr, b_clr, a_ovf, b_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_ctrl u_a (
    .clk(clk), .reset(reset), .wr_request(a_req), .rd_ptr(a_rd),
    .wr_ptr(a_ptr), .wr_en(a_en), .full_flag(a_full), .almost_full(a_af), .occupancy(a_occ)
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    , .clr_overflow(a_clr), .overflow_flag(a_ovf)
`endif
  );

  fifo_wr_ctrl #(.W_DATA_WIDTH(32)) u_b (
    .clk(clk), .reset(reset), .wr_request(b_req), .rd_ptr(b_rd),
    .wr_ptr(b_ptr), .wr_en(b_en), .full_flag(b_full), .almost_full(b_af), .occupancy(b_occ)
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    , .clr_overflow(b_clr), .overflow_flag(b_ovf)
`endif
  );

  typedef struct {
    logic       req;
    logic [4:0] rd;
    logic [4:0] e_ptr;
    logic       e_en;
    logic       e_full;
    logic       e_af;
    logic [4:0] e_occ;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    a_rd  = '0;   b_rd  = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds the request for n beats; returns at a negedge with the request dropped.
  task automatic write_n(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (which == 0) a_req = 1'b1; else b_req = 1'b1;
    end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Model tracks total words written/read as plain integers; pointers are those totals mod 32.
  task automatic rand_run(input int which, input int wpw, input int n);
    int  wr_total, rd_total, occ, free;
    bit  req, e_full, e_af, e_en;
    logic [4:0] p, o;
    logic en, fl, af;
    do_reset();
    wr_total = 0;
    rd_total = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      occ = wr_total - rd_total;
      if ($urandom % 4 == 0) rd_total += int'($urandom_range(occ));
      req = ($urandom % 4) != 0;
      if (which == 0) begin a_req = req; a_rd = 5'(rd_total % 32); end
      else            begin b_req = req; b_rd = 5'(rd_total % 32); end
      #1;
      occ    = wr_total - rd_total;
      free   = 16 - occ;
      e_full = free < wpw;
      e_af   = free <= 2 * wpw;
      e_en   = req && !e_full;
      if (which == 0) begin p = a_ptr; o = a_occ; en = a_en; fl = a_full; af = a_af; end
      else            begin p = b_ptr; o = b_occ; en = b_en; fl = b_full; af = b_af; end
      check($sformatf("rand%0d ptr c%0d", which, c), int'(p), wr_total % 32);
      check($sformatf("rand%0d occ c%0d", which, c), int'(o), occ);
      check($sformatf("rand%0d full c%0d", which, c), int'(fl), int'(e_full));
      check($sformatf("rand%0d afull c%0d", which, c), int'(af), int'(e_af));
      check($sformatf("rand%0d wr_en c%0d", which, c), int'(en), int'(e_en));
      if (e_en) wr_total += wpw;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    // Fill sequence from empty: almost_full from occupancy 14, full at 16, then dropped requests.
    for (int i = 0; i < 19; i++) begin
      tbl[i].req = 1'b1;
      tbl[i].rd  = 5'd0;
      if (i < 16) begin
        tbl[i].e_ptr = 5'(i); tbl[i].e_en = 1'b1; tbl[i].e_full = 1'b0;
        tbl[i].e_af  = (i >= 14); tbl[i].e_occ = 5'(i);
      end else begin
        tbl[i].e_ptr = 5'd16; tbl[i].e_en = 1'b0; tbl[i].e_full = 1'b1;
        tbl[i].e_af  = 1'b1;  tbl[i].e_occ = 5'd16;
      end
    end

    reset = 1'b1;
    a_req = 1'b1; b_req = 1'b0;
    a_rd  = '0;   b_rd  = '0;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    a_clr = 1'b0; b_clr = 1'b0;
`endif
    #2;
    check("reset ptr", int'(a_ptr), 0);
    check("reset occ", int'(a_occ), 0);
    check("reset full", int'(a_full), 0);
    check("reset afull", int'(a_af), 0);
    check("reset wr_en follows req", int'(a_en), 1);
    check("reset b afull", int'(b_af), 0);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      a_req = tbl[i].req;
      a_rd  = tbl[i].rd;
      #1;
      check($sformatf("vec%0d ptr", i), int'(a_ptr), int'(tbl[i].e_ptr));
      check($sformatf("vec%0d wr_en", i), int'(a_en), int'(tbl[i].e_en));
      check($sformatf("vec%0d full", i), int'(a_full), int'(tbl[i].e_full));
      check($sformatf("vec%0d afull", i), int'(a_af), int'(tbl[i].e_af));
      check($sformatf("vec%0d occ", i), int'(a_occ), int'(tbl[i].e_occ));
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    check("full hold ptr", int'(a_ptr), 16);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    check("overflow set", int'(a_ovf), 1);
    @(negedge clk);
    #1;
    check("overflow sticky", int'(a_ovf), 1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    #1;
    check("overflow cleared", int'(a_ovf), 0);
`endif

    // Read side frees a slot on negedge; the write at the next posedge is accepted.
    @(negedge clk);
    a_req = 1'b1;
    a_rd  = 5'd1;
    #1;
    check("simul wr_en", int'(a_en), 1);
    check("simul full", int'(a_full), 0);
    @(negedge clk);
    a_req = 1'b0;
    #1;
    check("simul ptr", int'(a_ptr), 17);
    check("simul full again", int'(a_full), 1);
    check("simul wr_en off", int'(a_en), 0);

    // Wrap-around: reach wr_ptr=30 with rd_ptr=20, then cross the wrap.
    do_reset();
    write_n(0, 16);
    a_rd = 5'd16;
    write_n(0, 14);
    a_rd = 5'd20;
    #1;
    check("wrap start ptr", int'(a_ptr), 30);
    check("wrap start occ", int'(a_occ), 10);
    write_n(0, 1);
    #1;
    check("wrap ptr 31", int'(a_ptr), 31);
    write_n(0, 1);
    #1;
    check("wrap ptr 0", int'(a_ptr), 0);
    write_n(0, 4);
    #1;
    check("wrap ptr 4", int'(a_ptr), 4);
    check("wrap occ", int'(a_occ), 16);
    check("wrap full", int'(a_full), 1);
    a_rd = 5'd21;
    #1;
    check("wrap freed full", int'(a_full), 0);
    check("wrap freed occ", int'(a_occ), 15);

    // Asynchronous reset between edges with a write pending.
    do_reset();
    write_n(0, 9);
    #1;
    check("midrst ptr before", int'(a_ptr), 9);
    @(negedge clk);
    a_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midrst ptr async", int'(a_ptr), 0);
    check("midrst occ", int'(a_occ), 0);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    check("midrst overflow", int'(a_ovf), 0);
`endif
    @(negedge clk);
    a_req = 1'b0;
    reset = 1'b0;

    // WPW=2 instance.
    do_reset();
    write_n(1, 7);
    #1;
    check("wpw2 ptr 14", int'(b_ptr), 14);
    check("wpw2 full 0", int'(b_full), 0);
    check("wpw2 afull", int'(b_af), 1);
    check("wpw2 occ 14", int'(b_occ), 14);
    write_n(1, 1);
    #1;
    check("wpw2 ptr 16", int'(b_ptr), 16);
    check("wpw2 full 1", int'(b_full), 1);
    b_rd = 5'd1;
    #1;
    check("wpw2 free1 full", int'(b_full), 1);
    check("wpw2 free1 occ", int'(b_occ), 15);
    b_rd = 5'd2;
    #1;
    check("wpw2 free2 full", int'(b_full), 0);
    b_req = 1'b1;
    #1;
    check("wpw2 free2 wr_en", int'(b_en), 1);
    b_req = 1'b0;

    rand_run(0, 1, 300);
    rand_run(1, 2, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
